// File: rtl/regfile_bram_mt.sv
// Multi-thread register file in block RAM with write-first bypass, hardware
// zero-initialisation after reset and a per-thread clear command.
`timescale 1ns/1ps
module regfile_bram_mt #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N_THREADS = 4,
  parameter int unsigned N_REGS    = 16,
  parameter int unsigned N_SRC     = 3,
  localparam int unsigned TH_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1,
  localparam int unsigned RA_W     = $clog2(N_REGS),
  localparam int unsigned TH_MSB   = TH_W - 1,
  localparam int unsigned RA_MSB   = RA_W - 1,
  localparam int unsigned SEL_W    = (N_SRC > 0) ? $clog2(N_SRC + 1) : 1
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       mem_din,
  input  logic [N_SRC*WIDTH-1:0] din_flat,
  input  logic [SEL_W-1:0]       din_select,
  input  logic                   mem_wr_en,
  input  logic                   wr_en,
  input  logic [TH_MSB:0]        wr_thread_num,
  input  logic [RA_MSB:0]        wr_addr,
  input  logic [TH_MSB:0]        rd_thread_num,
  input  logic [RA_MSB:0]        rd_addr,
  input  logic                   rd_en0,
  input  logic                   rd_en1,
  input  logic                   clr_en,
  input  logic [TH_MSB:0]        clr_thread_num,
  output logic [WIDTH-1:0]       dout,
  output logic                   ready,
  output logic                   wr_drop
);

  localparam int unsigned DEPTH = N_THREADS * N_REGS;
  localparam int unsigned AW    = TH_W + RA_W;

  typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [TH_MSB:0] clr_thr_q, clr_thr_d;
  logic            ready_q, ready_d;
  logic            wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0] rd0_q, rd0_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  // Storage; no output register and no reset so it maps onto a plain BRAM.
  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_req;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] wr_data_sel;
  logic [AW-1:0]    raddr;

  assign wr_req = mem_wr_en | wr_en;
  assign raddr  = {rd_thread_num, rd_addr};

  // Write-data source mux; out-of-range selects fall back to mem_din.
  always_comb begin
    wr_data_sel = mem_din;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      if (din_select == SEL_W'(k)) wr_data_sel = din_flat[k*WIDTH-1 -: WIDTH];
    end
  end

  // FSM next state and the single RAM write port arbitration.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_thr_d = clr_thr_q;
    wr_drop_d = wr_drop_q;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    unique case (state_q)
      StInit: begin
        we    = 1'b1;
        waddr = cnt_q;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StClear: begin
        we    = 1'b1;
        waddr = {clr_thr_q, cnt_q[RA_MSB:0]};
        cnt_d = cnt_q + AW'(1);
        if (cnt_q[RA_MSB:0] == RA_W'(N_REGS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        if (wr_req) begin
          we    = 1'b1;
          waddr = {wr_thread_num, wr_addr};
          wdata = wr_data_sel;
        end
        if (clr_en) begin
          clr_thr_d = clr_thread_num;
          cnt_d     = '0;
          state_d   = StClear;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
    if (wr_req && !ready_q) wr_drop_d = 1'b1;
    // Nothing is written while reset is held; INIT starts once it releases.
    if (!rst_n) we = 1'b0;
  end

  assign ready_d = (state_d == StIdle);

  // FSM state and registered status outputs.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      clr_thr_q <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_thr_q <= clr_thr_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // RAM write port.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read pipeline next values; stage 0 is write-first on an address match.
  always_comb begin
    rd0_d = rd0_q;
    if (rd_en0) rd0_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
    dout_d = rd_en1 ? rd0_q : dout_q;
  end

  // Read stage 0 and explicit output register.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      rd0_q  <= '0;
      dout_q <= '0;
    end else begin
      rd0_q  <= rd0_d;
      dout_q <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_bram_mt.sv
// Directed, table-driven bench for regfile_bram_mt (4 threads x 16 regs, 2 sources).
`timescale 1ns/1ps
module tb_regfile_bram_mt;

  localparam int unsigned W  = 16;
  localparam int unsigned NT = 4;
  localparam int unsigned NR = 16;
  localparam int unsigned NS = 2;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  mem_din;
  logic [NS*W-1:0] din_flat;
  logic [1:0]    din_select;
  logic          mem_wr_en, wr_en;
  logic [1:0]    wr_thread_num, rd_thread_num, clr_thread_num;
  logic [3:0]    wr_addr, rd_addr;
  logic          rd_en0, rd_en1, clr_en;
  logic [W-1:0]  dout;
  logic          ready, wr_drop;

  int checks   = 0;
  int failures = 0;

  regfile_bram_mt #(
    .WIDTH    (W),
    .N_THREADS(NT),
    .N_REGS   (NR),
    .N_SRC    (NS)
  ) dut (
    .CLK           (clk),
    .rst_n         (rst_n),
    .mem_din       (mem_din),
    .din_flat      (din_flat),
    .din_select    (din_select),
    .mem_wr_en     (mem_wr_en),
    .wr_en         (wr_en),
    .wr_thread_num (wr_thread_num),
    .wr_addr       (wr_addr),
    .rd_thread_num (rd_thread_num),
    .rd_addr       (rd_addr),
    .rd_en0        (rd_en0),
    .rd_en1        (rd_en1),
    .clr_en        (clr_en),
    .clr_thread_num(clr_thread_num),
    .dout          (dout),
    .ready         (ready),
    .wr_drop       (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  th;
    logic [3:0]  r;
    logic [1:0]  sel;
    logic        use_mem_en;
    logic [15:0] md;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] th, input logic [3:0] r, input logic [1:0] sel,
                          input logic [15:0] md, input logic [15:0] s1, input logic [15:0] s2,
                          input logic use_mem);
    wr_thread_num = th;
    wr_addr       = r;
    din_select    = sel;
    mem_din       = md;
    din_flat      = {s2, s1};
    mem_wr_en     = use_mem;
    wr_en         = ~use_mem;
    tick();
    mem_wr_en = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] th, input logic [3:0] r, output logic [15:0] val);
    rd_thread_num = th;
    rd_addr       = r;
    rd_en0        = 1'b1;
    tick();
    rd_en0 = 1'b0;
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    val    = dout;
  endtask

  // Releases reset and checks ready stays low for exactly NT*NR cycles.
  task automatic release_and_check_init();
    int early;
    early  = 0;
    rst_n  = 1'b1;
    for (int i = 0; i < NT * NR; i++) begin
      if (ready !== 1'b0) early++;
      tick();
    end
    check("init_busy_cycles", 16'(early), 16'd0);
    check("init_ready_after", {15'd0, ready}, 16'd1);
  endtask

  task automatic check_all(input string name, input logic [1:0] zero_th, input logic use_zero,
                           input logic [15:0] other);
    logic [15:0] v;
    logic [15:0] e;
    for (int t = 0; t < NT; t++) begin
      for (int r = 0; r < NR; r++) begin
        do_read(2'(t), 4'(r), v);
        e = (use_zero == 1'b0 || 2'(t) == zero_th) ? 16'h0000 : other;
        check(name, v, e);
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    vecs[0] = '{th: 2'd2, r: 4'd5,  sel: 2'd0, use_mem_en: 1'b0, md: 16'h1234, s1: 16'h0,
                s2: 16'h0,    exp: 16'h1234};
    vecs[1] = '{th: 2'd3, r: 4'd15, sel: 2'd2, use_mem_en: 1'b0, md: 16'h9999, s1: 16'h1111,
                s2: 16'hBEEF, exp: 16'hBEEF};
    vecs[2] = '{th: 2'd0, r: 4'd0,  sel: 2'd3, use_mem_en: 1'b1, md: 16'h5A5A, s1: 16'h1111,
                s2: 16'h2222, exp: 16'h5A5A};
    vecs[3] = '{th: 2'd1, r: 4'd3,  sel: 2'd1, use_mem_en: 1'b0, md: 16'h9999, s1: 16'h0C0D,
                s2: 16'h2222, exp: 16'h0C0D};
    vecs[4] = '{th: 2'd0, r: 4'd15, sel: 2'd2, use_mem_en: 1'b1, md: 16'h9999, s1: 16'h1111,
                s2: 16'h7777, exp: 16'h7777};
    vecs[5] = '{th: 2'd3, r: 4'd0,  sel: 2'd0, use_mem_en: 1'b0, md: 16'h0001, s1: 16'h1111,
                s2: 16'h2222, exp: 16'h0001};

    rst_n = 1'b0; mem_din = '0; din_flat = '0; din_select = '0; mem_wr_en = 1'b0;
    wr_en = 1'b0; wr_thread_num = '0; wr_addr = '0; rd_thread_num = '0; rd_addr = '0;
    rd_en0 = 1'b0; rd_en1 = 1'b0; clr_en = 1'b0; clr_thread_num = '0;
    @(negedge clk);
    tick();
    tick();
    check("reset_dout", dout, 16'h0000);
    check("reset_ready", {15'd0, ready}, 16'd0);
    check("reset_wr_drop", {15'd0, wr_drop}, 16'd0);
    release_and_check_init();
    check_all("init_zero", 2'd0, 1'b0, 16'h0000);

    // Source-select table.
    foreach (vecs[i]) do_write(vecs[i].th, vecs[i].r, vecs[i].sel, vecs[i].md, vecs[i].s1,
                               vecs[i].s2, vecs[i].use_mem_en);
    foreach (vecs[i]) begin
      do_read(vecs[i].th, vecs[i].r, v);
      check($sformatf("vec%0d_read", i), v, vecs[i].exp);
    end

    // Bypass: read and write of the same address in the same cycle.
    wr_thread_num = 2'd1; wr_addr = 4'd7; din_select = 2'd0; mem_din = 16'hA5A5; wr_en = 1'b1;
    rd_thread_num = 2'd1; rd_addr = 4'd7; rd_en0 = 1'b1;
    tick();
    wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    check("bypass_same", dout, 16'hA5A5);
    // Different register, same thread: old content returned.
    wr_thread_num = 2'd1; wr_addr = 4'd6; mem_din = 16'h3C3C; wr_en = 1'b1;
    rd_thread_num = 2'd1; rd_addr = 4'd7; rd_en0 = 1'b1;
    tick();
    wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    check("bypass_diff_reg", dout, 16'hA5A5);
    // Different thread, same register.
    wr_thread_num = 2'd2; wr_addr = 4'd7; mem_din = 16'h6666; wr_en = 1'b1;
    rd_thread_num = 2'd1; rd_addr = 4'd6; rd_en0 = 1'b1;
    tick();
    wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    check("bypass_diff_thread", dout, 16'h3C3C);

    // Hold behaviour of the two read stages.
    do_read(2'd2, 4'd5, v);
    check("hold_pre", v, 16'h1234);
    rd_thread_num = 2'd3; rd_addr = 4'd15; rd_en0 = 1'b1; rd_en1 = 1'b0;
    tick();
    check("hold_dout_rd_en1_low", dout, 16'h1234);
    rd_thread_num = 2'd0; rd_addr = 4'd15; rd_en0 = 1'b0; rd_en1 = 1'b1;
    tick();
    check("hold_stage0_load", dout, 16'hBEEF);
    tick();
    rd_en1 = 1'b0;
    check("hold_stage0_kept", dout, 16'hBEEF);

    // Clear of thread 1, with a write accepted alongside the clear request.
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++) do_write(2'(t), 4'(r), 2'd0, 16'hFFFF, 16'h0, 16'h0, 1'b0);
    check("pre_clear_drop", {15'd0, wr_drop}, 16'd0);
    clr_en = 1'b1; clr_thread_num = 2'd1;
    wr_thread_num = 2'd2; wr_addr = 4'd4; din_select = 2'd0; mem_din = 16'h4444; wr_en = 1'b1;
    tick();
    clr_en = 1'b0; wr_en = 1'b0;
    begin
      int busy_bad;
      busy_bad = 0;
      for (int i = 0; i < NR; i++) begin
        if (ready !== 1'b0) busy_bad++;
        if (i == 3) begin
          wr_thread_num = 2'd0; wr_addr = 4'd0; mem_din = 16'h1234; wr_en = 1'b1;
        end
        tick();
        wr_en = 1'b0;
      end
      check("clear_busy_cycles", 16'(busy_bad), 16'd0);
    end
    check("clear_ready_after", {15'd0, ready}, 16'd1);
    check("clear_wr_drop", {15'd0, wr_drop}, 16'd1);
    do_read(2'd2, 4'd4, v);
    check("write_with_clr", v, 16'h4444);
    do_write(2'd2, 4'd4, 2'd0, 16'hFFFF, 16'h0, 16'h0, 1'b0);
    check_all("after_clear", 2'd1, 1'b1, 16'hFFFF);

    // Reset in the middle of a clear restarts the full INIT.
    do_read(2'd0, 4'd1, v);
    check("pre_reset_dout", v, 16'hFFFF);
    clr_en = 1'b1; clr_thread_num = 2'd2;
    tick();
    clr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midclr_reset_dout", dout, 16'h0000);
    check("midclr_reset_drop", {15'd0, wr_drop}, 16'd0);
    check("midclr_reset_ready", {15'd0, ready}, 16'd0);
    release_and_check_init();
    check_all("reinit_zero", 2'd0, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
